regfile_seq: RTL and testbench
==============================

Name: regfile_seq

Overview:
- Command sequencer sitting directly upstream of the 16x16 single-address register file.
- Accepts one register-transfer command per handshake (ADD, SUB, LOADI, MOV) and drives the register file's shared address, read strobe, write data and write clock.
- Reads up to two source operands, computes a 16-bit result with flags, and writes it back with a glitch-free, setup/hold-safe write pulse.
- Returns a done pulse, the result and the flags to the controller.

Parameters:
- W, 16, data width; equals register file word width.
- AW, 4, register address width (16 registers).

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  sequencer idle, can accept a command.
- cmd_op  in  2  00 ADD, 01 SUB, 10 LOADI, 11 MOV.
- cmd_rd  in  AW  destination register.
- cmd_rs  in  AW  source A.
- cmd_rt  in  AW  source B (ADD/SUB only).
- cmd_imm  in  W  immediate (LOADI only).
- rf_addr  out  AW  register file address (shared by read and write).
- rf_rclk  out  1  register file read strobe.
- rf_wclk  out  1  register file write clock.
- rf_wdata  out  W  register file write data.
- rf_rdata  in  W  register file read data; combinational from rf_addr while rf_rclk=1.
- done  out  1  one-cycle pulse when write-back completes.
- result  out  W  last written value, held.
- flag_c  out  1  carry (ADD) / borrow (SUB) of last ADD/SUB.
- flag_z  out  1  result==0 of last ADD/SUB/MOV.

Behaviour:
- Reset values:
  - State IDLE.
  - cmd_ready=1 (combinational from IDLE).
  - rf_addr=0, rf_rclk=0, rf_wclk=0, rf_wdata=0.
  - done=0, result=0, flag_c=0, flag_z=0.
- All outputs are registered except cmd_ready.
- Accept: on a rising edge with cmd_valid&cmd_ready, latch op/rd/rs/rt/imm. cmd_valid while busy is ignored (no queueing).
- States: IDLE, RD_A, RD_B, EXEC, WR_SU, WR_PL, WR_HD.
- ADD/SUB: IDLE->RD_A->RD_B->EXEC->WR_SU->WR_PL->WR_HD->IDLE.
- MOV: IDLE->RD_A->EXEC->WR_SU->WR_PL->WR_HD->IDLE.
- LOADI: IDLE->WR_SU->WR_PL->WR_HD->IDLE.
- RD_A: rf_addr=rs, rf_rclk=1; opA captured from rf_rdata at the end of the cycle.
- RD_B: rf_addr=rt, rf_rclk=1; opB captured at the end of the cycle.
- rf_rclk=0 in all other states.
- EXEC arithmetic:
  - ADD: {c,r}=opA+opB, (W+1)-bit.
  - SUB: r=opA-opB, c=1 when opA<opB (unsigned borrow).
  - MOV: r=opA, flag_c unchanged.
  - flag_z=(r==0) for ADD/SUB/MOV.
  - LOADI: r=imm, flags unchanged.
- WR_SU: rf_addr=rd, rf_wdata=r, rf_wclk=0 (one cycle of setup).
- WR_PL: rf_wclk=1, addr/data held. The register file captures on this rising edge.
- WR_HD: rf_wclk=0, addr/data held (hold); done=1, result=r.
- IDLE: rf_wdata/rf_addr keep their last values.
- Latency from the accept edge to done high:
  - ADD/SUB: 6 cycles.
  - MOV: 5 cycles.
  - LOADI: 3 cycles.
  - cmd_ready returns the cycle after done (back-to-back accept allowed on that edge).
- rs==rt is legal (same register read twice). rd may equal rs/rt; operands are already captured before write.
- Reset mid-operation: all state and outputs return to reset values immediately (async).
  - If the WR_PL rising edge has occurred, that write is committed.
  - Otherwise no write occurs.
  - No done pulse is issued.
- rf_wclk must be driven directly from a flop; no gating logic on the path.

Decomposition:
- Shared package holds:
  - op encodings OP_ADD/OP_SUB/OP_LOADI/OP_MOV;
  - state encoding constants;
  - W/AW defaults.
- One natural sub-module, regfile_seq_alu: combinational ADD/SUB/MOV/LOADI result plus carry/zero. The FSM and write-pulse generation stay in the top.

Test Plan:
- Reset pulse mid-idle -> cmd_ready=1, rf_wclk=0, done=0, result=0, flags 0.
- LOADI rd=3 imm=0x1234 -> WR_SU/WR_PL/WR_HD on cycles 1-3; rf_wclk high only in cycle 2 with rf_addr=3, rf_wdata=0x1234; done in cycle 3; register file R3 reads 0x1234.
- R1=0xFFFF, R2=0x0001, ADD rd=4 -> rf_addr 1 then 2 under rf_rclk; result=0x0000, flag_c=1, flag_z=1; done 6 cycles after accept.
- R1=0x0003, R2=0x0005, SUB rd=1 -> result=0xFFFE, flag_c=1, flag_z=0; R1 overwritten. A subsequent MOV rd=5 rs=1 yields R5=0xFFFE with flag_c still 1.
- cmd_valid held high continuously with 3 queued commands -> each accepted only when cmd_ready=1; the others are ignored while busy; no lost or duplicated writes.
- Reset asserted during RD_B of an ADD -> rf_wclk never rises, destination unchanged. Reset during WR_HD -> write committed, no done.

Source files
------------

// File: rtl/regfile_seq_pkg.sv
// rtl/regfile_seq_pkg.sv - shared widths, op encodings and sequencer state encoding
package regfile_seq_pkg;

    localparam int DEF_W  = 16;
    localparam int DEF_AW = 4;

    typedef enum logic [1:0] {
        OP_ADD   = 2'b00,
        OP_SUB   = 2'b01,
        OP_LOADI = 2'b10,
        OP_MOV   = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD_A  = 3'd1,
        ST_RD_B  = 3'd2,
        ST_EXEC  = 3'd3,
        ST_WR_SU = 3'd4,
        ST_WR_PL = 3'd5,
        ST_WR_HD = 3'd6
    } state_e;

endpackage

// File: rtl/regfile_seq_alu.sv
// rtl/regfile_seq_alu.sv - combinational result, carry/borrow and zero for one command
module regfile_seq_alu
    import regfile_seq_pkg::*;
#(
    parameter int W = DEF_W
) (
    input  op_e          op,
    input  logic [W-1:0] opa,
    input  logic [W-1:0] opb,
    input  logic [W-1:0] imm,
    output logic [W-1:0] r,
    output logic         c,
    output logic         z
);

    logic [W:0] sum;

    always_comb begin
        sum = '0;
        r   = '0;
        c   = 1'b0;
        case (op)
            OP_ADD: begin
                sum = {1'b0, opa} + {1'b0, opb};
                r   = sum[W-1:0];
                c   = sum[W];
            end
            OP_SUB: begin
                r = opa - opb;
                c = (opa < opb);
            end
            OP_MOV:   r = opa;
            OP_LOADI: r = imm;
            default:  r = '0;
        endcase
        z = (r == '0);
    end

endmodule

// File: rtl/regfile_seq.sv
// rtl/regfile_seq.sv - command sequencer driving a single-address register file
module regfile_seq
    import regfile_seq_pkg::*;
#(
    parameter int W  = DEF_W,
    parameter int AW = DEF_AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_op,
    input  logic [AW-1:0] cmd_rd,
    input  logic [AW-1:0] cmd_rs,
    input  logic [AW-1:0] cmd_rt,
    input  logic [W-1:0]  cmd_imm,
    output logic [AW-1:0] rf_addr,
    output logic          rf_rclk,
    output logic          rf_wclk,
    output logic [W-1:0]  rf_wdata,
    input  logic [W-1:0]  rf_rdata,
    output logic          done,
    output logic [W-1:0]  result,
    output logic          flag_c,
    output logic          flag_z
);

    state_e        state, next_state;
    op_e           op_q;
    logic [AW-1:0] rd_q, rt_q;
    logic [W-1:0]  opa_q, opb_q;
    logic          pend_c, pend_z;
    logic          accept;
    op_e           alu_op;
    logic [W-1:0]  alu_r;
    logic          alu_c, alu_z;

    assign cmd_ready = (state == ST_IDLE);
    assign accept    = cmd_valid && cmd_ready;

    // LOADI skips the read/exec states, so in IDLE the ALU works straight
    // from the command bus; otherwise it works from the latched op.
    assign alu_op = (state == ST_IDLE) ? op_e'(cmd_op) : op_q;

    regfile_seq_alu #(.W(W)) u_alu (
        .op  (alu_op),
        .opa (opa_q),
        .opb (opb_q),
        .imm (cmd_imm),
        .r   (alu_r),
        .c   (alu_c),
        .z   (alu_z)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (cmd_valid)
                    next_state = (op_e'(cmd_op) == OP_LOADI) ? ST_WR_SU : ST_RD_A;
            end
            ST_RD_A:  next_state = (op_q == OP_MOV) ? ST_EXEC : ST_RD_B;
            ST_RD_B:  next_state = ST_EXEC;
            ST_EXEC:  next_state = ST_WR_SU;
            ST_WR_SU: next_state = ST_WR_PL;
            ST_WR_PL: next_state = ST_WR_HD;
            ST_WR_HD: next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
    end

    // Every register-file strobe is decoded from next_state and registered,
    // so each one comes straight off a flop and is valid for the whole
    // state it belongs to. Address/data settle one cycle before rf_wclk
    // rises and stay put for one cycle after it falls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q     <= OP_ADD;
            rd_q     <= '0;
            rt_q     <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            pend_c   <= 1'b0;
            pend_z   <= 1'b0;
            rf_addr  <= '0;
            rf_rclk  <= 1'b0;
            rf_wclk  <= 1'b0;
            rf_wdata <= '0;
            done     <= 1'b0;
            result   <= '0;
            flag_c   <= 1'b0;
            flag_z   <= 1'b0;
        end else begin
            if (accept) begin
                op_q <= op_e'(cmd_op);
                rd_q <= cmd_rd;
                rt_q <= cmd_rt;
            end
            if (state == ST_RD_A) opa_q <= rf_rdata;
            if (state == ST_RD_B) opb_q <= rf_rdata;

            rf_rclk <= (next_state == ST_RD_A) || (next_state == ST_RD_B);
            rf_wclk <= (next_state == ST_WR_PL);
            done    <= (next_state == ST_WR_HD);

            if (next_state == ST_RD_A) rf_addr <= cmd_rs;
            if (next_state == ST_RD_B) rf_addr <= rt_q;

            if (next_state == ST_WR_SU) begin
                rf_addr  <= (state == ST_IDLE) ? cmd_rd : rd_q;
                rf_wdata <= alu_r;
                pend_c   <= alu_c;
                pend_z   <= alu_z;
            end

            // Flags and result only become visible together with done, so a
            // reset before write-back leaves the controller-facing view clean.
            if (next_state == ST_WR_HD) begin
                result <= rf_wdata;
                if (op_q != OP_LOADI) flag_z <= pend_z;
                if (op_q == OP_ADD || op_q == OP_SUB) flag_c <= pend_c;
            end
        end
    end

endmodule

// File: tb/tb_regfile_seq.sv
// tb/tb_regfile_seq.sv - self-checking bench for regfile_seq with a behavioural register file
module tb_regfile_seq;

    localparam logic [1:0] C_ADD = 2'b00, C_SUB = 2'b01, C_LOADI = 2'b10, C_MOV = 2'b11;

    logic        clk, rst, cmd_valid, cmd_ready;
    logic [1:0]  cmd_op;
    logic [3:0]  cmd_rd, cmd_rs, cmd_rt;
    logic [15:0] cmd_imm;
    logic [3:0]  rf_addr;
    logic        rf_rclk, rf_wclk;
    logic [15:0] rf_wdata, rf_rdata;
    logic        done;
    logic [15:0] result;
    logic        flag_c, flag_z;

    int chk_cnt = 0;
    int pass_cnt = 0;

    logic [15:0] rf_mem [16];
    int          wr_count = 0;

    logic [15:0] ref_regs [16];
    logic        ref_c, ref_z;

    int          ob_lat, ob_nw, ob_wpos, ob_nr;
    logic [3:0]  ob_waddr;
    logic [15:0] ob_wdata;
    logic [3:0]  ob_ra [2];

    regfile_seq dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_rd(cmd_rd), .cmd_rs(cmd_rs), .cmd_rt(cmd_rt), .cmd_imm(cmd_imm),
        .rf_addr(rf_addr), .rf_rclk(rf_rclk), .rf_wclk(rf_wclk),
        .rf_wdata(rf_wdata), .rf_rdata(rf_rdata),
        .done(done), .result(result), .flag_c(flag_c), .flag_z(flag_z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge rf_wclk) begin
        rf_mem[rf_addr] <= rf_wdata;
        wr_count <= wr_count + 1;
    end
    assign rf_rdata = rf_rclk ? rf_mem[rf_addr] : 16'h0000;

    task automatic issue(input logic [1:0] op, input logic [3:0] rd, rs, rt, input logic [15:0] imm);
        bit ok;
        ok = 0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = op; cmd_rd = rd; cmd_rs = rs; cmd_rt = rt; cmd_imm = imm;
        for (int i = 0; i < 20; i++) begin
            if (cmd_ready) begin ok = 1; break; end
            @(negedge clk);
        end
        chk_cnt++;
        if (!ok) begin
            $display("FAIL accept_timeout cmd_ready got 0 expected 1 within 20 cycles");
            cmd_valid = 1'b0;
        end else pass_cnt++;
        @(posedge clk);
    endtask

    task automatic do_cmd(input logic [1:0] op, input logic [3:0] rd, rs, rt, input logic [15:0] imm);
        issue(op, rd, rs, rt, imm);
        ob_lat = -1; ob_nw = 0; ob_wpos = -1; ob_nr = 0; ob_waddr = 0; ob_wdata = 0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (c == 1) cmd_valid = 1'b0;
            if (rf_rclk) begin
                if (ob_nr < 2) ob_ra[ob_nr] = rf_addr;
                ob_nr++;
            end
            if (rf_wclk) begin ob_nw++; ob_wpos = c; ob_waddr = rf_addr; ob_wdata = rf_wdata; end
            if (done) begin ob_lat = c; break; end
        end
    endtask

    task automatic model(input logic [1:0] op, input logic [3:0] rd, rs, rt, input logic [15:0] imm,
                         output logic [15:0] exp_r, output int exp_lat);
        int a, b, s;
        a = int'(ref_regs[rs]);
        b = int'(ref_regs[rt]);
        case (op)
            C_ADD: begin s = a + b; ref_c = (s > 65535); exp_r = 16'(s % 65536); exp_lat = 6; end
            C_SUB: begin s = a - b; ref_c = (s < 0); exp_r = 16'((s + 65536) % 65536); exp_lat = 6; end
            C_MOV: begin exp_r = 16'(a); exp_lat = 5; end
            default: begin exp_r = imm; exp_lat = 3; end
        endcase
        if (op != C_LOADI) ref_z = (exp_r == 16'h0000);
        ref_regs[rd] = exp_r;
    endtask

    task automatic test_reset;
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = 0; cmd_rd = 0; cmd_rs = 0; cmd_rt = 0; cmd_imm = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk_cnt++; if (cmd_ready !== 1'b1) $display("FAIL reset_ready got %b expected 1", cmd_ready); else pass_cnt++;
        chk_cnt++; if (rf_wclk !== 1'b0 || rf_rclk !== 1'b0) $display("FAIL reset_strobes got wclk=%b rclk=%b expected 0/0", rf_wclk, rf_rclk); else pass_cnt++;
        chk_cnt++; if (done !== 1'b0) $display("FAIL reset_done got %b expected 0", done); else pass_cnt++;
        chk_cnt++; if (result !== 16'h0 || rf_wdata !== 16'h0 || rf_addr !== 4'h0) $display("FAIL reset_data got result=%h wdata=%h addr=%h expected 0", result, rf_wdata, rf_addr); else pass_cnt++;
        chk_cnt++; if (flag_c !== 1'b0 || flag_z !== 1'b0) $display("FAIL reset_flags got c=%b z=%b expected 0/0", flag_c, flag_z); else pass_cnt++;
    endtask

    task automatic test_loadi;
        do_cmd(C_LOADI, 4'd3, 4'd0, 4'd0, 16'h1234);
        chk_cnt++; if (ob_lat !== 3) $display("FAIL loadi_latency got %0d expected 3", ob_lat); else pass_cnt++;
        chk_cnt++; if (ob_nw !== 1 || ob_wpos !== 2) $display("FAIL loadi_wclk got count=%0d cycle=%0d expected 1/2", ob_nw, ob_wpos); else pass_cnt++;
        chk_cnt++; if (ob_waddr !== 4'd3 || ob_wdata !== 16'h1234) $display("FAIL loadi_wbus got addr=%h data=%h expected 3/1234", ob_waddr, ob_wdata); else pass_cnt++;
        chk_cnt++; if (ob_nr !== 0) $display("FAIL loadi_reads got %0d expected 0", ob_nr); else pass_cnt++;
        chk_cnt++; if (rf_mem[3] !== 16'h1234) $display("FAIL loadi_r3 got %h expected 1234", rf_mem[3]); else pass_cnt++;
        chk_cnt++; if (result !== 16'h1234 || flag_c !== 1'b0 || flag_z !== 1'b0) $display("FAIL loadi_out got result=%h c=%b z=%b expected 1234/0/0", result, flag_c, flag_z); else pass_cnt++;
    endtask

    task automatic test_add;
        do_cmd(C_LOADI, 4'd1, 4'd0, 4'd0, 16'hFFFF);
        do_cmd(C_LOADI, 4'd2, 4'd0, 4'd0, 16'h0001);
        do_cmd(C_ADD, 4'd4, 4'd1, 4'd2, 16'h0000);
        chk_cnt++; if (ob_nr !== 2 || ob_ra[0] !== 4'd1 || ob_ra[1] !== 4'd2) $display("FAIL add_reads got n=%0d a0=%h a1=%h expected 2/1/2", ob_nr, ob_ra[0], ob_ra[1]); else pass_cnt++;
        chk_cnt++; if (ob_lat !== 6 || ob_wpos !== 5) $display("FAIL add_timing got done=%0d wclk=%0d expected 6/5", ob_lat, ob_wpos); else pass_cnt++;
        chk_cnt++; if (result !== 16'h0000 || flag_c !== 1'b1 || flag_z !== 1'b1) $display("FAIL add_out got result=%h c=%b z=%b expected 0000/1/1", result, flag_c, flag_z); else pass_cnt++;
        chk_cnt++; if (rf_mem[4] !== 16'h0000) $display("FAIL add_r4 got %h expected 0000", rf_mem[4]); else pass_cnt++;
    endtask

    task automatic test_sub_mov;
        do_cmd(C_LOADI, 4'd1, 4'd0, 4'd0, 16'h0003);
        do_cmd(C_LOADI, 4'd2, 4'd0, 4'd0, 16'h0005);
        do_cmd(C_SUB, 4'd1, 4'd1, 4'd2, 16'h0000);
        chk_cnt++; if (result !== 16'hFFFE || flag_c !== 1'b1 || flag_z !== 1'b0) $display("FAIL sub_out got result=%h c=%b z=%b expected fffe/1/0", result, flag_c, flag_z); else pass_cnt++;
        chk_cnt++; if (rf_mem[1] !== 16'hFFFE || ob_lat !== 6) $display("FAIL sub_r1 got r1=%h lat=%0d expected fffe/6", rf_mem[1], ob_lat); else pass_cnt++;
        do_cmd(C_MOV, 4'd5, 4'd1, 4'd0, 16'h0000);
        chk_cnt++; if (rf_mem[5] !== 16'hFFFE) $display("FAIL mov_r5 got %h expected fffe", rf_mem[5]); else pass_cnt++;
        chk_cnt++; if (flag_c !== 1'b1 || flag_z !== 1'b0) $display("FAIL mov_flags got c=%b z=%b expected 1/0", flag_c, flag_z); else pass_cnt++;
        chk_cnt++; if (ob_lat !== 5 || ob_nr !== 1 || ob_ra[0] !== 4'd1) $display("FAIL mov_timing got lat=%0d reads=%0d a0=%h expected 5/1/1", ob_lat, ob_nr, ob_ra[0]); else pass_cnt++;
    endtask

    task automatic test_back_to_back;
        logic [1:0]  ops [3];
        logic [3:0]  rds [3], rss [3], rts [3];
        logic [15:0] imms [3];
        int acc [3];
        int k, ndone, w0;
        ops[0] = C_LOADI; rds[0] = 4'd7; rss[0] = 4'd0; rts[0] = 4'd0; imms[0] = 16'hA5A5;
        ops[1] = C_MOV;   rds[1] = 4'd8; rss[1] = 4'd7; rts[1] = 4'd0; imms[1] = 16'h1111;
        ops[2] = C_ADD;   rds[2] = 4'd9; rss[2] = 4'd7; rts[2] = 4'd8; imms[2] = 16'h2222;
        for (int i = 0; i < 3; i++) acc[i] = -100;
        k = 0; ndone = 0;
        @(negedge clk);
        w0 = wr_count;
        cmd_valid = 1'b1; cmd_op = ops[0]; cmd_rd = rds[0]; cmd_rs = rss[0]; cmd_rt = rts[0]; cmd_imm = imms[0];
        for (int cyc = 0; cyc < 30; cyc++) begin
            if (done) ndone++;
            if (k < 3 && cmd_ready) begin acc[k] = cyc; k++; end
            @(negedge clk);
            if (k >= 3) cmd_valid = 1'b0;
            else begin cmd_op = ops[k]; cmd_rd = rds[k]; cmd_rs = rss[k]; cmd_rt = rts[k]; cmd_imm = imms[k]; end
        end
        chk_cnt++; if (acc[1] - acc[0] !== 4) $display("FAIL b2b_gap1 got %0d expected 4", acc[1] - acc[0]); else pass_cnt++;
        chk_cnt++; if (acc[2] - acc[1] !== 6) $display("FAIL b2b_gap2 got %0d expected 6", acc[2] - acc[1]); else pass_cnt++;
        chk_cnt++; if (wr_count - w0 !== 3 || ndone !== 3) $display("FAIL b2b_counts got writes=%0d dones=%0d expected 3/3", wr_count - w0, ndone); else pass_cnt++;
        chk_cnt++; if (rf_mem[7] !== 16'hA5A5 || rf_mem[8] !== 16'hA5A5 || rf_mem[9] !== 16'h4B4A) $display("FAIL b2b_regs got %h %h %h expected a5a5 a5a5 4b4a", rf_mem[7], rf_mem[8], rf_mem[9]); else pass_cnt++;
        chk_cnt++; if (result !== 16'h4B4A || flag_c !== 1'b1 || flag_z !== 1'b0) $display("FAIL b2b_out got result=%h c=%b z=%b expected 4b4a/1/0", result, flag_c, flag_z); else pass_cnt++;
    endtask

    task automatic test_reset_mid;
        int w0, ndone;
        do_cmd(C_LOADI, 4'd10, 4'd0, 4'd0, 16'h0BAD);
        do_cmd(C_LOADI, 4'd11, 4'd0, 4'd0, 16'h0001);
        do_cmd(C_LOADI, 4'd12, 4'd0, 4'd0, 16'h0002);
        w0 = wr_count;
        issue(C_ADD, 4'd10, 4'd11, 4'd12, 16'h0000);
        @(negedge clk); cmd_valid = 1'b0;
        @(negedge clk);
        chk_cnt++; if (rf_rclk !== 1'b1 || rf_addr !== 4'd12) $display("FAIL rst_rdb_state got rclk=%b addr=%h expected 1/c", rf_rclk, rf_addr); else pass_cnt++;
        rst = 1'b1;
        #1;
        chk_cnt++; if (cmd_ready !== 1'b1 || rf_rclk !== 1'b0 || rf_wclk !== 1'b0) $display("FAIL rst_async got ready=%b rclk=%b wclk=%b expected 1/0/0", cmd_ready, rf_rclk, rf_wclk); else pass_cnt++;
        @(negedge clk); rst = 1'b0;
        ndone = 0;
        repeat (8) begin @(negedge clk); if (done) ndone++; end
        chk_cnt++; if (wr_count - w0 !== 0 || ndone !== 0) $display("FAIL rst_rdb_nowrite got writes=%0d dones=%0d expected 0/0", wr_count - w0, ndone); else pass_cnt++;
        chk_cnt++; if (rf_mem[10] !== 16'h0BAD) $display("FAIL rst_rdb_r10 got %h expected 0bad", rf_mem[10]); else pass_cnt++;

        w0 = wr_count;
        issue(C_LOADI, 4'd13, 4'd0, 4'd0, 16'h7777);
        @(negedge clk); cmd_valid = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        ndone = 0;
        @(negedge clk); if (done) ndone++;
        rst = 1'b0;
        repeat (6) begin @(negedge clk); if (done) ndone++; end
        chk_cnt++; if (rf_mem[13] !== 16'h7777 || wr_count - w0 !== 1) $display("FAIL rst_hd_commit got r13=%h writes=%0d expected 7777/1", rf_mem[13], wr_count - w0); else pass_cnt++;
        chk_cnt++; if (ndone !== 0 || result !== 16'h0000) $display("FAIL rst_hd_nodone got dones=%0d result=%h expected 0/0000", ndone, result); else pass_cnt++;
    endtask

    task automatic test_random;
        logic [1:0]  op;
        logic [3:0]  rd, rs, rt;
        logic [15:0] imm, exp_r;
        int          exp_lat;
        ref_c = 1'b0; ref_z = 1'b0;
        for (int i = 0; i < 16; i++) begin
            imm = 16'($urandom);
            do_cmd(C_LOADI, 4'(i), 4'd0, 4'd0, imm);
            ref_regs[i] = imm;
        end
        for (int n = 0; n < 40; n++) begin
            op = 2'($urandom_range(0, 3));
            rd = 4'($urandom); rs = 4'($urandom); rt = 4'($urandom);
            if (n % 8 == 0) rt = rs;
            if (n % 8 == 3) rd = rs;
            imm = (n % 10 == 5) ? 16'h0000 : 16'($urandom);
            model(op, rd, rs, rt, imm, exp_r, exp_lat);
            do_cmd(op, rd, rs, rt, imm);
            chk_cnt++; if (ob_lat !== exp_lat) $display("FAIL rnd%0d_latency op=%0d got %0d expected %0d", n, op, ob_lat, exp_lat); else pass_cnt++;
            chk_cnt++; if (result !== exp_r) $display("FAIL rnd%0d_result op=%0d got %h expected %h", n, op, result, exp_r); else pass_cnt++;
            chk_cnt++; if (flag_c !== ref_c || flag_z !== ref_z) $display("FAIL rnd%0d_flags op=%0d got c=%b z=%b expected %b/%b", n, op, flag_c, flag_z, ref_c, ref_z); else pass_cnt++;
            chk_cnt++; if (rf_mem[rd] !== exp_r || ob_nw !== 1) $display("FAIL rnd%0d_write got r%0d=%h writes=%0d expected %h/1", n, rd, rf_mem[rd], ob_nw, exp_r); else pass_cnt++;
        end
        for (int i = 0; i < 16; i++) begin
            chk_cnt++; if (rf_mem[i] !== ref_regs[i]) $display("FAIL rnd_final_r%0d got %h expected %h", i, rf_mem[i], ref_regs[i]); else pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_loadi();
        test_add();
        test_sub_mov();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
